// File: rtl/mersenne_mac_pipe.sv
// Pipelined multiply-accumulate modulo M = 2^W-1 with valid/ready streaming on both sides.
// One global enable stalls every stage together so backpressure never drops or reorders beats.
module mersenne_mac_pipe #(
  parameter int unsigned W          = 32,
  parameter int unsigned MUL_STAGES = 1
) (
  input  logic         axi_aclk,
  input  logic         axi_aresetn,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_a,
  input  logic [W-1:0] s_b,
  input  logic         s_acc,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic         m_last
);

  localparam int unsigned PW = 2 * W;
  localparam logic [W-1:0] MOD = '1;

  // End-around-carry fold of a W+1-bit sum into the canonical range [0, M-1].
  function automatic logic [W-1:0] fold_sum(input logic [W:0] x);
    logic [W-1:0] r;
    r = x[W-1:0] + W'(x[W]);
    return (r == MOD) ? '0 : r;
  endfunction

  logic en;
  assign en      = !m_valid || m_ready;
  assign s_ready = en;

  logic         s0_valid;
  logic [W-1:0] s0_a;
  logic [W-1:0] s0_b;
  logic         s0_acc;
  logic         s0_last;

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      s0_valid <= 1'b0;
      s0_a     <= '0;
      s0_b     <= '0;
      s0_acc   <= 1'b0;
      s0_last  <= 1'b0;
    end else if (en) begin
      s0_valid <= s_valid;
      s0_a     <= s_a;
      s0_b     <= s_b;
      s0_acc   <= s_acc;
      s0_last  <= s_acc && s_last;
    end
  end

  // Multiplier: first stage forms the full product, the rest are retiming registers.
  logic [PW-1:0]         p_data [MUL_STAGES];
  logic [MUL_STAGES-1:0] p_valid;
  logic [MUL_STAGES-1:0] p_acc;
  logic [MUL_STAGES-1:0] p_last;

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      for (int unsigned i = 0; i < MUL_STAGES; i++) begin
        p_data[i] <= '0;
      end
      p_valid <= '0;
      p_acc   <= '0;
      p_last  <= '0;
    end else if (en) begin
      p_data[0]  <= PW'(s0_a) * PW'(s0_b);
      p_valid[0] <= s0_valid;
      p_acc[0]   <= s0_acc;
      p_last[0]  <= s0_last;
      for (int unsigned i = 1; i < MUL_STAGES; i++) begin
        p_data[i]  <= p_data[i-1];
        p_valid[i] <= p_valid[i-1];
        p_acc[i]   <= p_acc[i-1];
        p_last[i]  <= p_last[i-1];
      end
    end
  end

  logic [PW-1:0] p_tail;
  logic [W:0]    p_sum;
  assign p_tail = p_data[MUL_STAGES-1];
  assign p_sum  = {1'b0, p_tail[W-1:0]} + {1'b0, p_tail[PW-1:W]};

  logic         f_valid;
  logic [W-1:0] f_data;
  logic         f_acc;
  logic         f_last;

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      f_valid <= 1'b0;
      f_data  <= '0;
      f_acc   <= 1'b0;
      f_last  <= 1'b0;
    end else if (en) begin
      f_valid <= p_valid[MUL_STAGES-1];
      f_data  <= fold_sum(p_sum);
      f_acc   <= p_acc[MUL_STAGES-1];
      f_last  <= p_last[MUL_STAGES-1];
    end
  end

  logic [W-1:0] acc;
  logic [W-1:0] acc_next;
  assign acc_next = fold_sum({1'b0, acc} + {1'b0, f_data});

  // Output/accumulate stage: single beats bypass acc, so they may interleave with a packet.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      acc     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (en) begin
      if (f_valid && !f_acc) begin
        m_valid <= 1'b1;
        m_data  <= f_data;
        m_last  <= 1'b0;
      end else if (f_valid && f_last) begin
        m_valid <= 1'b1;
        m_data  <= acc_next;
        m_last  <= 1'b1;
        acc     <= '0;
      end else begin
        m_valid <= 1'b0;
        if (f_valid) begin
          acc <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_mersenne_mac_pipe.sv
// Scoreboard bench for mersenne_mac_pipe: a driver pushes expected results from a modular
// arithmetic model, an independent monitor pops and compares on every output handshake.
module tb_mersenne_mac_pipe;
  localparam int unsigned W  = 32;
  localparam int unsigned MS = 1;
  localparam longint unsigned M = (64'd1 << W) - 64'd1;

  logic         clk;
  logic         rst_n;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_a;
  logic [W-1:0] s_b;
  logic         s_acc;
  logic         s_last;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_last;

  mersenne_mac_pipe #(.W(W), .MUL_STAGES(MS)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .s_acc(s_acc), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  exp_t            q[$];
  int              errors = 0;
  int              checks = 0;
  int              bp_mode = 0;
  longint unsigned acc_m = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint unsigned mulmod(input longint unsigned a, input longint unsigned b);
    return (a * b) % M;
  endfunction

  // Downstream ready: 0 always ready, 1 random, 2 held low.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ($urandom_range(0, 2) != 0);
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: protocol rules plus in-order comparison against the scoreboard.
  initial begin
    logic         hold;
    logic [W-1:0] hold_data;
    logic         hold_last;
    exp_t         e;
    hold = 1'b0;
    hold_data = '0;
    hold_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        chk("s_ready_rule", 64'(s_ready), 64'(!m_valid || m_ready));
        if (hold) begin
          chk("stall_valid", 64'(m_valid), 64'd1);
          chk("stall_data", 64'(m_data), 64'(hold_data));
          chk("stall_last", 64'(m_last), 64'(hold_last));
        end
        hold = m_valid && !m_ready;
        hold_data = m_data;
        hold_last = m_last;
        if (m_valid && m_ready) begin
          if (q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_output: got data 0x%0h last %0d, none expected", m_data, m_last);
          end else begin
            e = q.pop_front();
            chk("out_data", 64'(m_data), 64'(e.data));
            chk("out_last", 64'(m_last), 64'(e.last));
          end
        end
      end
    end
  end

  // Issue one beat; record the expected response once the handshake has happened.
  task automatic send(input longint unsigned a, input longint unsigned b, input bit acc, input bit last);
    bit ok;
    longint unsigned p;
    int n;
    s_valid = 1'b1;
    s_a     = W'(a);
    s_b     = W'(b);
    s_acc   = acc;
    s_last  = last;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      n++;
    end
    #1;
    s_valid = 1'b0;
    if (!ok) begin
      chk("send_timeout", 64'd0, 64'd1);
    end else begin
      p = mulmod(a % (M + 1), b % (M + 1));
      if (!acc) begin
        q.push_back('{data: W'(p), last: 1'b0});
      end else if (last) begin
        q.push_back('{data: W'((acc_m + p) % M), last: 1'b1});
        acc_m = 0;
      end else begin
        acc_m = (acc_m + p) % M;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic longint unsigned pick();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return M;
      2:       return M - 1;
      default: return longint'(W'($urandom));
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit acc;
    bit last;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_a = '0;
    s_b = '0;
    s_acc = 1'b0;
    s_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // All-ones operand is congruent to zero; also measures accept-to-output latency.
    send(M, 5, 0, 0);
    n = 1;
    while (n < 20) begin
      @(negedge clk);
      if (m_valid) break;
      n++;
    end
    chk("latency", 64'(n), 64'(MS + 3));
    chk("latency_data", 64'(m_data), 64'd0);
    drain();

    send(64'h8000_0000 & M, 2, 0, 0);
    send(M - 1, M - 1, 0, 0);
    send(64'h1234_5678 & M, 1, 0, 0);
    drain();

    send(2, 3, 1, 0);
    send(4, 5, 1, 0);
    send(6, 7, 1, 1);
    send(9, 9, 1, 1);
    drain();

    // Stall downstream mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) send(64'(i + 10), 64'(3 * i + 1), 0, 0);
      end
      begin
        repeat (3) @(posedge clk);
        bp_mode = 2;
        repeat (5) @(negedge clk);
        chk("stall_s_ready", 64'(s_ready), 64'd0);
        repeat (5) @(posedge clk);
        bp_mode = 0;
      end
    join
    drain();

    send(1, 1, 1, 0);
    send(3, 3, 0, 0);
    send(2, 2, 1, 1);
    drain();

    // Reset mid-packet discards the partial accumulator.
    send(11, 12, 1, 0);
    send(13, 14, 1, 0);
    rst_n = 1'b0;
    acc_m = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send(7, 7, 1, 1);
    drain();

    // Random beats under random backpressure.
    bp_mode = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      acc  = ($urandom_range(0, 2) != 0);
      last = acc && ($urandom_range(0, 3) == 0);
      send(pick(), pick(), acc, last);
    end
    send(pick(), pick(), 1, 1);
    drain();
    bp_mode = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
